// File: rtl/switch_debouncer_4ch.sv
// switch_debouncer_4ch
//   Conditions four raw, asynchronous, bouncy switch lines into clean,
//   clock-synchronous levels a, b, c, d. Each channel has its own
//   two-flop synchroniser and stability counter. A new level is accepted
//   only after it has been seen unchanged for STABLE_CYCLES consecutive
//   cycles at the synchroniser output. change_stb is a registered
//   one-cycle pulse that is high on the same edge as any accepted change.
//   Several channels toggling on the same edge produce one pulse.

module switch_debouncer_4ch #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       change_stb
);

  // Terminal count: the counter is held at or below this value and never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Synchroniser stages. Nothing sits between sync1_r and sync2_r.
  logic [3:0]           sync1_r;
  logic [3:0]           sync2_r;

  // Debounced levels and their stability counters.
  logic [3:0]           out_r;
  logic [3:0]           out_next_s;
  logic [CNT_WIDTH-1:0] cnt_r      [4];
  logic [CNT_WIDTH-1:0] cnt_next_s [4];

  // Change strobe.
  logic                 stb_r;
  logic                 stb_next_s;

  // Two-flop synchroniser for all four raw switch lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel stability check: count while the synchronised level
  // differs from the accepted one, and accept it once the count reaches
  // the terminal value. A return to the accepted level clears the count,
  // so a bounce shorter than STABLE_CYCLES never reaches the output.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_next_s[i] = out_r[i];
      cnt_next_s[i] = CNT_ZERO;
      if (sync2_r[i] == out_r[i]) begin
        cnt_next_s[i] = CNT_ZERO;
      end else if (cnt_r[i] >= CNT_MAX) begin
        out_next_s[i] = sync2_r[i];
        cnt_next_s[i] = CNT_ZERO;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Strobe request: any channel whose accepted level changes on this edge.
  always_comb begin
    stb_next_s = 1'b0;
    if (out_next_s != out_r) begin
      stb_next_s = 1'b1;
    end else begin
      stb_next_s = 1'b0;
    end
  end

  // Debounced level, counter and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= 4'b0000;
      stb_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      out_r <= out_next_s;
      stb_r <= stb_next_s;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  // Bit 3 of the vector maps to a, down to bit 0 mapping to d.
  assign a          = out_r[3];
  assign b          = out_r[2];
  assign c          = out_r[1];
  assign d          = out_r[0];
  assign change_stb = stb_r;

endmodule

// File: tb/tb_switch_debouncer_4ch.sv
// Testbench for switch_debouncer_4ch with STABLE_CYCLES=4, CNT_WIDTH=3.
// Stimulus pushes the expected vector and edge number of every accepted
// change into a queue; a monitor pops one entry per change_stb pulse.
module tb_switch_debouncer_4ch;

  localparam int S = 4;

  typedef struct packed {
    logic [3:0] vec;
    int         edge_no;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] sw_in;
  logic       a, b, c, d;
  logic       change_stb;

  int   total;
  int   bad;
  int   cyc;
  bit   mon_en;
  logic [3:0] prev_vec;
  exp_t exp_q[$];

  switch_debouncer_4ch #(.STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_in      (sw_in),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .change_stb (change_stb)
  );

  // Clock: first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; edge number n is the nth rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the next queued change, and the
  // output vector must never move without a strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (change_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("stb_vec", int'({a, b, c, d}), int'(e.vec));
          check("stb_edge", cyc, e.edge_no);
        end
      end else begin
        check("steady_vec", int'({a, b, c, d}), int'(prev_vec));
      end
      prev_vec <= {a, b, c, d};
    end
  end

  // Drive a new switch vector at a falling edge; if it differs from the
  // accepted vector, its acceptance is due S+1 edges after the next edge.
  task automatic step(input logic [3:0] v, input bit chg);
    exp_t e;
    sw_in = v;
    if (chg) begin
      e.vec     = v;
      e.edge_no = cyc + 1 + S + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    prev_vec = 4'b0000;
    reset    = 1'b1;
    sw_in    = 4'b1111;

    // 1. Reset held for 3 edges with all switches high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_vec", int'({a, b, c, d}), 0);
      check("reset_stb", int'(change_stb), 0);
    end
    reset  = 1'b0;
    sw_in  = 4'b0000;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_release_vec", int'({a, b, c, d}), 0);
    check("post_release_stb", int'(change_stb), 0);

    // 2. Single-channel step on a.
    step(4'b1000, 1'b1);
    wait_cyc(10);

    // 3. Return a to 0, then a 3-cycle bounce that must be rejected,
    //    then a 4-cycle pulse that is just long enough to be accepted.
    step(4'b0000, 1'b1);
    wait_cyc(10);
    step(4'b1000, 1'b0);
    wait_cyc(3);
    step(4'b0000, 1'b0);
    wait_cyc(10);
    step(4'b1000, 1'b1);
    wait_cyc(4);
    step(4'b0000, 1'b1);
    wait_cyc(12);

    // 4. Two channels change together: one strobe.
    step(4'b0110, 1'b1);
    wait_cyc(10);
    step(4'b0000, 1'b1);
    wait_cyc(10);

    // 5. Reset arrives mid-count; the count restarts after release.
    step(4'b1111, 1'b0);
    wait_cyc(3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midcount_reset_vec", int'({a, b, c, d}), 0);
    end
    reset = 1'b0;
    step(4'b1111, 1'b1);
    wait_cyc(10);

    // 6. Walk all sixteen vectors, each held 10 cycles.
    for (int v = 0; v < 16; v++) begin
      step(4'(v), 1'b1);
      wait_cyc(10);
      check("walk_vec", int'({a, b, c, d}), v);
    end

    wait_cyc(5);
    check("pending_changes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
